pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the IF stage, replacing the single-register PC. Holds the word-addressed PC and selects the next PC from reset, exception, exception-return, branch, jump/call and return sources under a fixed priority. A small circular return-address stack (RAS) serves return targets. It drives the instruction-memory address and gives IF/ID a redirect indication.

---
 rtl/pc_sequencer.sv | 132 +++++++++++++
 tb/tb_pc_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// IF-stage program-counter sequencer: prioritised next-PC selection with a
// small circular return-address stack for call/return prediction.
module pc_sequencer #(
  parameter int                ADDR_W     = 30,
  parameter logic [ADDR_W-1:0] START_ADDR = 30'h0000BFF,
  parameter logic [ADDR_W-1:0] EXC_VEC    = 30'h0000060,
  parameter int                RAS_DEPTH  = 4,
  parameter int                CW         = $clog2(RAS_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_en,
  input  logic              exc,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp,
  input  logic              call,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic [ADDR_W-1:0] link_addr,
  input  logic              ret,
  input  logic [ADDR_W-1:0] ret_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W+1:0] pc_byte,
  output logic              redirect,
  output logic [CW-1:0]     ras_count,
  output logic              ras_ovf
);

  localparam int                TPW     = $clog2(RAS_DEPTH);
  localparam logic [TPW-1:0]    TP_MAX  = TPW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0]     DEPTH_C = CW'(RAS_DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic              r_redirect;
  logic [CW-1:0]     r_ras_count;
  logic              r_ras_ovf;
  logic [TPW-1:0]    r_tp;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

  logic [ADDR_W-1:0] w_next_pc;
  logic              w_next_redirect;
  logic              w_push;
  logic              w_pop;
  logic [TPW-1:0]    w_tp_inc;
  logic [TPW-1:0]    w_tp_dec;

  // Top-pointer arithmetic wraps modulo RAS_DEPTH, which need not be a power of two.
  always_comb begin
    w_tp_inc = (r_tp == TP_MAX) ? {TPW{1'b0}} : (r_tp + TPW'(1));
    w_tp_dec = (r_tp == {TPW{1'b0}}) ? TP_MAX : (r_tp - TPW'(1));
  end

  // Next-PC arbitration; the RAS only moves when its own source wins.
  always_comb begin
    w_next_pc       = r_pc;
    w_next_redirect = r_redirect;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    if (exc) begin
      w_next_pc       = EXC_VEC;
      w_next_redirect = 1'b1;
    end else if (eret) begin
      w_next_pc       = epc;
      w_next_redirect = 1'b1;
    end else if (!pc_en) begin
      w_next_pc       = r_pc;
      w_next_redirect = r_redirect;
    end else if (br_taken) begin
      w_next_pc       = br_target;
      w_next_redirect = 1'b1;
    end else if (jmp) begin
      w_next_pc       = jmp_target;
      w_next_redirect = 1'b1;
      w_push          = call;
    end else if (ret) begin
      w_next_redirect = 1'b1;
      if (r_ras_count != {CW{1'b0}}) begin
        w_next_pc = r_ras[r_tp];
        w_pop     = 1'b1;
      end else begin
        w_next_pc = ret_target;
      end
    end else begin
      w_next_pc       = r_pc + ADDR_W'(1);
      w_next_redirect = 1'b0;
    end
  end

  // PC, redirect flag and RAS bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= START_ADDR;
      r_redirect  <= 1'b0;
      r_ras_count <= {CW{1'b0}};
      r_ras_ovf   <= 1'b0;
      r_tp        <= {TPW{1'b0}};
    end else begin
      r_pc       <= w_next_pc;
      r_redirect <= w_next_redirect;
      if (w_push) begin
        r_tp <= w_tp_inc;
        if (r_ras_count == DEPTH_C) begin
          r_ras_ovf <= 1'b1;
        end else begin
          r_ras_count <= r_ras_count + CW'(1);
        end
      end else if (w_pop) begin
        r_tp        <= w_tp_dec;
        r_ras_count <= r_ras_count - CW'(1);
      end else begin
        r_tp        <= r_tp;
        r_ras_count <= r_ras_count;
      end
    end
  end

  // RAS storage has no reset; a push when full overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_ras[w_tp_inc] <= link_addr;
    end
  end

  assign pc        = r_pc;
  assign pc_byte   = {r_pc, 2'b00};
  assign redirect  = r_redirect;
  assign ras_count = r_ras_count;
  assign ras_ovf   = r_ras_ovf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer with default parameters.
module tb_pc_sequencer;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          reset, pc_en, exc, eret, br_taken, jmp, call, ret;
  logic [AW-1:0] epc, br_target, jmp_target, link_addr, ret_target;
  logic [AW-1:0] pc;
  logic [AW+1:0] pc_byte;
  logic          redirect;
  logic [2:0]    ras_count;
  logic          ras_ovf;

  typedef struct {
    logic          rst, en, ex, er, br, jp, cl, rt;
    logic [AW-1:0] epc_v, brt, jt, lnk, rtt;
    logic [AW-1:0] e_pc;
    logic          e_red;
    logic [2:0]    e_cnt;
    logic          e_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_miss = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .exc(exc), .eret(eret), .epc(epc),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .call(call),
    .jmp_target(jmp_target), .link_addr(link_addr), .ret(ret), .ret_target(ret_target),
    .pc(pc), .pc_byte(pc_byte), .redirect(redirect), .ras_count(ras_count), .ras_ovf(ras_ovf)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, en, ex, er, br, jp, cl, rt,
                     input logic [AW-1:0] epc_v, brt, jt, lnk, rtt,
                     input logic [AW-1:0] e_pc, input logic e_red,
                     input logic [2:0] e_cnt, input logic e_ovf);
    vec_t v;
    v.rst = rst; v.en = en; v.ex = ex; v.er = er; v.br = br; v.jp = jp; v.cl = cl; v.rt = rt;
    v.epc_v = epc_v; v.brt = brt; v.jt = jt; v.lnk = lnk; v.rtt = rtt;
    v.e_pc = e_pc; v.e_red = e_red; v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [AW+1:0] exp_byte;
    @(negedge clk);
    reset = v.rst; pc_en = v.en; exc = v.ex; eret = v.er; br_taken = v.br;
    jmp = v.jp; call = v.cl; ret = v.rt; epc = v.epc_v; br_target = v.brt;
    jmp_target = v.jt; link_addr = v.lnk; ret_target = v.rtt;
    @(posedge clk);
    #1;
    n_vec++;
    exp_byte = {v.e_pc, 2'b00};
    if (pc !== v.e_pc) begin
      n_miss++; $display("FAIL vec%0d pc: got %h want %h", idx, pc, v.e_pc);
    end
    if (pc_byte !== exp_byte) begin
      n_miss++; $display("FAIL vec%0d pc_byte: got %h want %h", idx, pc_byte, exp_byte);
    end
    if (redirect !== v.e_red) begin
      n_miss++; $display("FAIL vec%0d redirect: got %b want %b", idx, redirect, v.e_red);
    end
    if (ras_count !== v.e_cnt) begin
      n_miss++; $display("FAIL vec%0d ras_count: got %0d want %0d", idx, ras_count, v.e_cnt);
    end
    if (ras_ovf !== v.e_ovf) begin
      n_miss++; $display("FAIL vec%0d ras_ovf: got %b want %b", idx, ras_ovf, v.e_ovf);
    end
  endtask

  initial begin
    reset = 1'b1; pc_en = 1'b0; exc = 1'b0; eret = 1'b0; br_taken = 1'b0;
    jmp = 1'b0; call = 1'b0; ret = 1'b0; epc = '0; br_target = '0;
    jmp_target = '0; link_addr = '0; ret_target = '0;

    //   rst en ex er br jp cl rt  epc     brt           jt      lnk     rtt       e_pc          red cnt ovf
    add(1, 0, 0, 0, 0, 0, 0, 0, 30'h0,   30'h0,        30'h0,   30'h0,   30'h0,   30'hBFF,      0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 30'h0,   30'h0,        30'h0,   30'h0,   30'h0,   30'hC00,      0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 30'h0,   30'h0,        30'h0,   30'h0,   30'h0,   30'hC01,      0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 30'h0,   30'h0,        30'h0,   30'h0,   30'h0,   30'hC02,      0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 30'h0,   30'h0,        30'h0,   30'h0,   30'h0,   30'hC03,      0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 0, 1, 0, 0, 0, 30'h0, 30'h200,      30'h0,   30'h0,   30'h0,   30'hC03,      0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 30'h0,   30'h0,        30'h0,   30'h0,   30'h0,   30'h060,      1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 1, 0, 30'h0,   30'h0,        30'h100, 30'hC05, 30'h0,   30'h100,      1, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 30'h0,   30'h0,        30'h0,   30'h0,   30'h777, 30'hC05,      1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 30'h0,   30'h0,        30'h0,   30'h0,   30'h0,   30'hC06,      0, 0, 0);
    // five calls into a four-deep RAS
    for (int i = 0; i < 5; i++)
      add(0, 1, 0, 0, 0, 1, 1, 0, 30'h0, 30'h0, 30'h400, 30'hA1 + 30'(i), 30'h0,
          30'h400, 1, (i < 4) ? 3'(i + 1) : 3'd4, (i == 4) ? 1'b1 : 1'b0);
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 0, 0, 0, 0, 1, 30'h0, 30'h0, 30'h0, 30'h0, 30'h777,
          30'hA5 - 30'(i), 1, 3'(3 - i), 1);
    add(0, 1, 0, 0, 0, 0, 0, 1, 30'h0,   30'h0,        30'h0,   30'h0,   30'h777, 30'h777,      1, 0, 1);
    add(0, 1, 0, 0, 1, 1, 1, 1, 30'h0,   30'h200,      30'h300, 30'hBBB, 30'h777, 30'h200,      1, 0, 1);
    add(0, 1, 0, 0, 0, 1, 1, 1, 30'h0,   30'h0,        30'h300, 30'h3AB, 30'h777, 30'h300,      1, 1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1, 30'h0,   30'h0,        30'h0,   30'h0,   30'h777, 30'h3AB,      1, 0, 1);
    add(0, 1, 0, 0, 1, 0, 0, 0, 30'h0,   30'h3FFFFFFF, 30'h0,   30'h0,   30'h0,   30'h3FFFFFFF, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 30'h0,   30'h0,        30'h0,   30'h0,   30'h0,   30'h0,        0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 30'h123, 30'h0,        30'h0,   30'h0,   30'h0,   30'h123,      1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 30'h0,   30'h200,      30'h0,   30'h0,   30'h0,   30'h123,      1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 30'h0,   30'h0,        30'h0,   30'h0,   30'h0,   30'hBFF,      0, 0, 0);

    foreach (vecs[i]) apply(vecs[i], i);

    // exc/eret must not touch the RAS even with ret asserted; reset beats exc.
    vecs.delete();
    add(0, 1, 0, 0, 0, 1, 1, 0, 30'h0,   30'h0,  30'h500, 30'h5A5, 30'h0,   30'h500, 1, 1, 0);
    add(0, 1, 1, 0, 0, 0, 0, 1, 30'h0,   30'h0,  30'h0,   30'h0,   30'h777, 30'h060, 1, 1, 0);
    add(0, 1, 0, 1, 0, 0, 0, 1, 30'h321, 30'h0,  30'h0,   30'h0,   30'h777, 30'h321, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0, 30'h0,   30'h0,  30'h0,   30'h0,   30'h0,   30'h322, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 30'h0,   30'h0,  30'h0,   30'h0,   30'h777, 30'h5A5, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 1, 0, 30'h0,   30'h0,  30'h600, 30'h6A6, 30'h0,   30'h600, 1, 1, 0);
    add(1, 1, 1, 0, 0, 0, 0, 1, 30'h0,   30'h0,  30'h0,   30'h0,   30'h777, 30'hBFF, 0, 0, 0);
    foreach (vecs[i]) apply(vecs[i], 100 + i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
